// File: rtl/mesh_spm_pkg.sv
// Shared types and default sizing for the mesh-to-SPM egress path.
package mesh_spm_pkg;

  localparam int unsigned DEFAULT_FIFO_WIDTH   = 36;
  localparam int unsigned DEFAULT_BURST_LEN    = 4;
  localparam int unsigned DEFAULT_REGION_WORDS = 256;

  typedef logic [DEFAULT_FIFO_WIDTH-1:0] egress_word_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } drain_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant, with wrap.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand     = (32'(last_grant) + k) % N;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
        grant     = N'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/mesh_egress_drain_sched.sv
// Round-robin burst drain of mesh egress FIFOs into per-PE circular SPM regions.
// Optional per-PE word counters enabled by defining MESH_DRAIN_PERF_EN.
module mesh_egress_drain_sched
  import mesh_spm_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH    = DEFAULT_FIFO_WIDTH,
  parameter int unsigned NUM_EGRESS_PE = 2,
  parameter int unsigned BURST_LEN     = DEFAULT_BURST_LEN,
  parameter int unsigned REGION_WORDS  = DEFAULT_REGION_WORDS,
  parameter int unsigned SPM_ADDR_W    = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [NUM_EGRESS_PE-1:0]         egress_empty,
  input  logic [FIFO_WIDTH-1:0]            egress_rdata [NUM_EGRESS_PE],
  output logic [NUM_EGRESS_PE-1:0]         egress_dequeue,
  output logic                             spm_wr_valid,
  input  logic                             spm_wr_ready,
  output logic [SPM_ADDR_W-1:0]            spm_wr_addr,
  output logic [FIFO_WIDTH-1:0]            spm_wr_data,
  output logic [$clog2(NUM_EGRESS_PE)-1:0] sel,
  output logic                             busy,
  output logic [31:0]                      perf_words [NUM_EGRESS_PE]
);

  localparam int unsigned IDX_W = $clog2(NUM_EGRESS_PE);
  localparam int unsigned PTR_W = $clog2(REGION_WORDS);
  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_PE   = IDX_W'(NUM_EGRESS_PE - 1);

  drain_state_e state_q, state_d;
  logic [IDX_W-1:0] sel_q, last_grant_q, grant_idx;
  logic [CNT_W-1:0] burst_cnt_q;
  logic [PTR_W-1:0] wr_ptr_q [NUM_EGRESS_PE];
  logic [NUM_EGRESS_PE-1:0] grant_oh;
  logic in_drain, cur_empty, handshake, grant_now;

  rr_arbiter #(
    .N     (NUM_EGRESS_PE),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (~egress_empty),
    .last_grant (last_grant_q),
    .grant      (grant_oh),
    .grant_idx  (grant_idx)
  );

  // Outputs are gated by rst_n so nothing is written or popped in a reset cycle.
  always_comb begin
    in_drain       = rst_n && (state_q == DRAIN);
    cur_empty      = egress_empty[sel_q];
    spm_wr_valid   = in_drain && !cur_empty;
    handshake      = spm_wr_valid && spm_wr_ready;
    grant_now      = (state_q == IDLE) && enable && (|grant_oh);
    spm_wr_data    = in_drain ? egress_rdata[sel_q] : '0;
    spm_wr_addr    = in_drain ? SPM_ADDR_W'({sel_q, wr_ptr_q[sel_q]}) : '0;
    egress_dequeue = '0;
    egress_dequeue[sel_q] = handshake;
    busy           = in_drain;
    sel            = sel_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_now) state_d = DRAIN;
      DRAIN:   if (cur_empty || (handshake && burst_cnt_q == LAST_BEAT)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q        <= '0;
      last_grant_q <= LAST_PE;
      burst_cnt_q  <= '0;
      for (int unsigned i = 0; i < NUM_EGRESS_PE; i++) wr_ptr_q[i] <= '0;
    end else begin
      if (grant_now) begin
        sel_q        <= grant_idx;
        last_grant_q <= grant_idx;
        burst_cnt_q  <= '0;
      end
      // Pointer width equals log2(REGION_WORDS), so natural overflow is the region wrap.
      if (handshake) begin
        wr_ptr_q[sel_q] <= wr_ptr_q[sel_q] + PTR_W'(1);
        burst_cnt_q     <= burst_cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef MESH_DRAIN_PERF_EN
  logic [31:0] perf_q [NUM_EGRESS_PE];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_EGRESS_PE; i++) perf_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_EGRESS_PE; i++) begin
        if (handshake && sel_q == IDX_W'(i) && perf_q[i] != '1)
          perf_q[i] <= perf_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_EGRESS_PE; i++) perf_words[i] = perf_q[i];
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < NUM_EGRESS_PE; i++) perf_words[i] = '0;
  end
`endif

endmodule

// File: tb/tb_mesh_egress_drain_sched.sv
// Self-checking bench: queue-based FIFO sources, transaction-level scheduler model.
module tb_mesh_egress_drain_sched;

  localparam int unsigned W  = 36;
  localparam int unsigned N  = 2;
  localparam int unsigned BL = 4;
  localparam int unsigned RW = 256;
  localparam int unsigned AW = 10;
`ifdef MESH_DRAIN_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, enable, spm_wr_ready;
  logic [N-1:0]  egress_empty, egress_dequeue;
  logic [W-1:0]  egress_rdata [N];
  logic          spm_wr_valid, busy;
  logic [AW-1:0] spm_wr_addr;
  logic [W-1:0]  spm_wr_data;
  logic [0:0]    sel;
  logic [31:0]   perf_words [N];

  always #5 clk = ~clk;

  mesh_egress_drain_sched #(
    .FIFO_WIDTH    (W),
    .NUM_EGRESS_PE (N),
    .BURST_LEN     (BL),
    .REGION_WORDS  (RW),
    .SPM_ADDR_W    (AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .egress_empty   (egress_empty),
    .egress_rdata   (egress_rdata),
    .egress_dequeue (egress_dequeue),
    .spm_wr_valid   (spm_wr_valid),
    .spm_wr_ready   (spm_wr_ready),
    .spm_wr_addr    (spm_wr_addr),
    .spm_wr_data    (spm_wr_data),
    .sel            (sel),
    .busy           (busy),
    .perf_words     (perf_words)
  );

  // FIFO contents owned by the bench (first-word-fall-through view).
  logic [W-1:0] q0[$], q1[$];
  int checks = 0, errors = 0, cyc = 0;

  // Reference model state.
  bit     m_busy = 1'b0;
  int     m_sel = 0, m_last = N - 1, m_cnt = 0;
  int     m_ptr [N] = '{0, 0};
  longint m_perf [N] = '{0, 0};
  int     log_addr[$], log_sel[$], log_cyc[$], grant_log[$];

  function automatic int qsize(input int pe);
    return (pe == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [W-1:0] qhead(input int pe);
    if (qsize(pe) == 0) return '0;
    return (pe == 0) ? q0[0] : q1[0];
  endfunction

  task automatic refresh();
    egress_empty[0] = (q0.size() == 0);
    egress_empty[1] = (q1.size() == 0);
    egress_rdata[0] = qhead(0);
    egress_rdata[1] = qhead(1);
  endtask

  task automatic push(input int pe);
    logic [W-1:0] w;
    w = {4'(pe), 32'($urandom)};
    if (pe == 0) q0.push_back(w);
    else         q1.push_back(w);
    refresh();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, then model advance, then FIFO pops.
  always begin : cmp
    bit live, ev, hs;
    logic [N-1:0] deq_snap;
    @(negedge clk); #1;
    live = rst_n && m_busy;
    ev   = live && (qsize(m_sel) != 0);
    hs   = ev && spm_wr_ready;
    chk("valid", spm_wr_valid, ev);
    chk("busy", busy, live);
    chk("sel", sel, m_sel);
    chk("addr", spm_wr_addr, live ? m_sel * RW + m_ptr[m_sel] : 0);
    chk("data", spm_wr_data, live ? qhead(m_sel) : '0);
    for (int i = 0; i < N; i++) begin
      chk("dequeue", egress_dequeue[i], hs && (i == m_sel));
      chk("perf", perf_words[i], PERF ? m_perf[i] : 0);
    end
    deq_snap = egress_dequeue;
    if (hs) begin
      log_addr.push_back(m_sel * RW + m_ptr[m_sel]);
      log_sel.push_back(m_sel);
      log_cyc.push_back(cyc);
    end
    if (!rst_n) begin
      m_busy = 0; m_sel = 0; m_last = N - 1; m_cnt = 0;
      for (int i = 0; i < N; i++) begin m_ptr[i] = 0; m_perf[i] = 0; end
    end else if (!m_busy) begin
      if (enable && (qsize(0) != 0 || qsize(1) != 0)) begin
        for (int k = N; k >= 1; k--)
          if (qsize((m_last + k) % N) != 0) m_sel = (m_last + k) % N;
        m_last = m_sel; m_busy = 1; m_cnt = 0;
        grant_log.push_back(m_sel);
      end
    end else if (qsize(m_sel) == 0) begin
      m_busy = 0;
    end else if (spm_wr_ready) begin
      m_ptr[m_sel] = (m_ptr[m_sel] + 1) % RW;
      if (m_perf[m_sel] < 64'hFFFF_FFFF) m_perf[m_sel]++;
      m_cnt++;
      if (m_cnt == BL) m_busy = 0;
    end
    cyc++;
    @(posedge clk); #1;
    if (deq_snap[0] && q0.size() != 0) void'(q0.pop_front());
    if (deq_snap[1] && q1.size() != 0) void'(q1.pop_front());
    refresh();
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_sel.delete(); log_cyc.delete(); grant_log.delete();
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0; enable = 1'b0; spm_wr_ready = 1'b1;
    q0.delete(); q1.delete(); refresh();
    tick(); tick();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_busy(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(); #2;
      seen = busy;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: busy not seen within 10 cycles", tag);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; spm_wr_ready = 1'b0;
    refresh();

    // Reset state
    do_reset();
    #2;
    chk("rst_valid", spm_wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", spm_wr_addr, 0);
    chk("rst_data", spm_wr_data, 0);
    chk("rst_sel", sel, 0);
    chk("rst_deq", egress_dequeue, 0);

    // Single PE, continuous ready
    tick();
    for (int i = 0; i < 3; i++) push(0);
    enable = 1'b1;
    repeat (10) tick();
    chk("single_count", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      chk("single_a0", log_addr[0], 0);
      chk("single_a1", log_addr[1], 1);
      chk("single_a2", log_addr[2], 2);
      chk("single_span", log_cyc[2] - log_cyc[0], 2);
      chk("single_sel", log_sel[0] + log_sel[1] + log_sel[2], 0);
    end
    #2 chk("single_idle", busy, 0);

    // Both PEs loaded with 10 words
    do_reset();
    for (int i = 0; i < 10; i++) begin push(0); push(1); end
    enable = 1'b1;
    repeat (40) tick();
    chk("both_count", log_addr.size(), 20);
    chk("both_grants", grant_log.size(), 6);
    if (grant_log.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("both_order", grant_log[i], i % 2);
    end
    if (log_addr.size() == 20) begin
      chk("both_pe1_first", log_addr[4], 256);
      chk("both_bubble", log_cyc[4] - log_cyc[3], 2);
    end
    #2;
    chk("both_perf0", perf_words[0], PERF ? 10 : 0);
    chk("both_perf1", perf_words[1], PERF ? 10 : 0);

    // Backpressure: ready 1,0,0,1 mid-burst
    do_reset();
    for (int i = 0; i < 6; i++) push(0);
    enable = 1'b1; spm_wr_ready = 1'b1;
    tick(); spm_wr_ready = 1'b1;
    tick(); spm_wr_ready = 1'b0;
    tick(); spm_wr_ready = 1'b0;
    tick(); spm_wr_ready = 1'b1;
    repeat (15) tick();
    chk("bp_count", log_addr.size(), 6);
    if (log_addr.size() >= 2) chk("bp_gap", log_cyc[1] - log_cyc[0], 3);

    // Region wrap on PE1
    do_reset();
    for (int i = 0; i < 258; i++) push(1);
    enable = 1'b1;
    repeat (420) tick();
    chk("wrap_count", log_addr.size(), 258);
    if (log_addr.size() == 258) begin
      chk("wrap_first", log_addr[0], 256);
      chk("wrap_last_pre", log_addr[255], 511);
      chk("wrap_257", log_addr[256], 256);
      chk("wrap_258", log_addr[257], 257);
    end

    // Truncation after 2 words, then enable dropped mid-burst
    do_reset();
    push(0); push(0);
    enable = 1'b1;
    repeat (8) tick();
    chk("trunc_count", log_addr.size(), 2);
    chk("trunc_grants", grant_log.size(), 1);
    #2 chk("trunc_idle", busy, 0);
    clear_logs();
    tick();
    for (int i = 0; i < 8; i++) push(0);
    wait_busy("enable_drop");
    enable = 1'b0;
    repeat (15) tick();
    chk("endrop_count", log_addr.size(), 4);
    chk("endrop_left", q0.size(), 4);
    #2 chk("endrop_idle", busy, 0);

    // Reset mid-burst
    do_reset();
    for (int i = 0; i < 8; i++) push(0);
    enable = 1'b1;
    wait_busy("reset_mid");
    tick(); tick();
    rst_n = 1'b0;
    #2;
    chk("rstmid_valid", spm_wr_valid, 0);
    chk("rstmid_deq", egress_dequeue, 0);
    tick();
    rst_n = 1'b1;
    #2;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_addr", spm_wr_addr, 0);
    chk("rstmid_pre", log_addr.size(), 2);
    clear_logs();
    repeat (20) tick();
    chk("rstmid_count", log_addr.size(), 6);
    if (log_addr.size() != 0) chk("rstmid_ptr0", log_addr[0], 0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n        = ($urandom_range(0, 499) != 0);
      enable       = ($urandom_range(0, 9) != 0);
      spm_wr_ready = ($urandom_range(0, 3) != 0);
      for (int pe = 0; pe < N; pe++)
        if ($urandom_range(0, 2) == 0 && qsize(pe) < 24) push(pe);
    end
    rst_n = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
